cache_resp_model: RTL and testbench
===================================

# cache_resp_model

Cycle-accurate responder for the core-to-cache request interface: it answers the pulsed read/write requests from the core side (or from the debug traffic generator) with `*_fin` completions and read data. It models a direct-mapped cache (hit vs. miss latency) over a small backing RAM. It replaces the real cache in core-level and debug-core simulations, so initiators can be verified against controlled, repeatable latencies.

## Interface
- `HIT_LAT`, 2: cycles from request-enable to `fin` on a tag hit; legal range 2..255.
- `MISS_LAT`, 8: cycles from request-enable to `fin` on a miss; legal range `HIT_LAT`..255.
- `MEM_AW`, 10: backing RAM address width; RAM holds 2^MEM_AW 32-bit words indexed by `addr[MEM_AW-1:0]`.
- `clk`, input, 1: sole clock, rising edge.
- `rstn`, input, 1: reset, synchronous, active-low.
- `core2cache_rd_addr`, input, 27: read address = {tag[12:0], index[9:0], offset[3:0]}.
- `core2cache_wr_addr`, input, 27: write address, same split.
- `core2cache_wr_data`, input, 32: write data.
- `core2cache_rd_en`, input, 1: single-cycle read request pulse.
- `core2cache_wr_en`, input, 1: single-cycle write request pulse.
- `cache2core_rd_fin`, output, 1: one-cycle read completion.
- `cache2core_wr_fin`, output, 1: one-cycle write completion.
- `cache2core_rd_data`, output, 32: read data; valid in the `rd_fin` cycle and held until the next `rd_fin`.

## Operation
- FSM states: IDLE, LOOKUP, WAIT, RESP.
- IDLE, en sampled high in cycle t:
  - Latch the address, data and op type.
  - Go to LOOKUP.
- LOOKUP, cycle t+1:
  - Compare `addr[26:14]` with the tag entry at `addr[13:4]`; hit means valid and tag equal.
  - Load the counter with `lat-2`, where `lat` is `HIT_LAT` or `MISS_LAT`.
  - Go to RESP if the counter load is 0, else WAIT.
- WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
- RESP, cycle t+lat:
  - Assert the matching `fin` for exactly one cycle.
  - Write: update RAM at `addr[MEM_AW-1:0]`.
  - Read: drive `rd_data` from RAM.
  - Miss (read or write): install the tag and set valid.
  - Next state: IDLE, or LOOKUP if a pending read exists.
- Simultaneous `rd_en` and `wr_en` in IDLE:
  - The write is serviced first.
  - The read is latched as pending and enters LOOKUP the cycle after the write's `fin` (its t = write RESP cycle).
  - The pending read observes the written data.
- Any en outside IDLE is ignored and not queued.
- Read of a never-written RAM word returns undefined data; benches only read written words.
- Tag wrap: 13-bit tag compare is exact, with no aliasing beyond the direct-mapped index.
- Reset values:
  - `rd_fin=0`, `wr_fin=0`, `rd_data=0`.
  - State IDLE, counter 0, pending cleared.
  - All 1024 valid bits cleared.
  - RAM contents are not reset.
- Reset mid-operation (any state): the transaction is dropped, no `fin` is issued, and the FSM is back in IDLE in the first cycle after `rstn` rises.

## Timing
- Latency is exactly `HIT_LAT` or `MISS_LAT` cycles from the en-sampled cycle to the `fin` cycle.
- `fin` and `rd_data` are registered outputs.
- At most one outstanding transaction, plus one pending read only in the simultaneous case.
- Earliest next request: en sampled in the cycle after `fin`; back-to-back hit throughput is one op per `HIT_LAT+1` cycles.
- `rd_fin` and `wr_fin` are never high in the same cycle.

## Configuration
- `CACHE_RESP_STATS_EN`
  - Defined: adds output ports `stat_hit_cnt[31:0]`, `stat_miss_cnt[31:0]` and `stat_drop_cnt[15:0]`.
    - Hit/miss counters increment in LOOKUP.
    - The drop counter increments for each en ignored outside IDLE.
    - All counters reset to 0 and saturate at all-ones.
  - Undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- Shared package `cache_pkg` holds:
  - `ADDR_W=27`, `TAG_W=13`, `INDEX_W=10`, `OFFSET_W=4`, `DATA_W=32`.
  - The FSM state enum.
  - Field-extract functions for tag, index and offset.
- Sub-module `cache_resp_tag_array`:
  - 1024 x (valid+13-bit tag).
  - Combinational lookup port and synchronous install port.
  - Synchronous valid clear on reset.

## Test plan
- Reset, then write 0x0000_0001 to addr 0x0000_01C (cold): `wr_fin` is high exactly 8 cycles after `wr_en`; `stat_miss_cnt`=1.
- Read addr 0x0000_01C after that write: hit, `rd_fin` 2 cycles after `rd_en`, `rd_data`=0x0000_0001.
- Write addr 0x0200_01C (same index, new tag), then read 0x0000_01C: both are misses at 8 cycles each, and the read returns the value just written, since RAM aliasing follows `addr[9:0]`.
- `rd_en` and `wr_en` both high (wr 0x5 to addr 0x40, rd addr 0x40):
  - `wr_fin` at t+8.
  - `rd_fin` at t+8+2, with `rd_data`=0x5.
- `wr_en` pulsed again during WAIT: no extra `fin`, `stat_drop_cnt`=1.
- `rstn` low during WAIT of a miss read: no `rd_fin`, `rd_data`=0, and the same address misses afterwards.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state type and address field helpers
//
// Purpose: common definitions for the cache response model, its bus
// interface and its tag array.
// Ports: none (package).
package cache_pkg;

  localparam int ADDR_W    = 27;
  localparam int TAG_W     = 13;
  localparam int INDEX_W   = 10;
  localparam int OFFSET_W  = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_RESP
  } cache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_resp_model_if.sv
// rtl/cache_resp_model_if.sv - core-to-cache request/completion bus
//
// Purpose: groups the pulsed request and completion signals.
// Ports (signals): core2cache_rd_addr/wr_addr/wr_data/rd_en/wr_en from the
// initiator; cache2core_rd_fin/wr_fin/rd_data from the responder.
// Modports: master (initiator side), slave (responder side).
interface cache_resp_model_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0] core2cache_rd_addr;
  logic [ADDR_W-1:0] core2cache_wr_addr;
  logic [DATA_W-1:0] core2cache_wr_data;
  logic              core2cache_rd_en;
  logic              core2cache_wr_en;
  logic              cache2core_rd_fin;
  logic              cache2core_wr_fin;
  logic [DATA_W-1:0] cache2core_rd_data;

  modport master (
    output core2cache_rd_addr, core2cache_wr_addr, core2cache_wr_data,
    output core2cache_rd_en, core2cache_wr_en,
    input  cache2core_rd_fin, cache2core_wr_fin, cache2core_rd_data
  );

  modport slave (
    input  core2cache_rd_addr, core2cache_wr_addr, core2cache_wr_data,
    input  core2cache_rd_en, core2cache_wr_en,
    output cache2core_rd_fin, cache2core_wr_fin, cache2core_rd_data
  );

endinterface

// File: rtl/cache_resp_tag_array.sv
// rtl/cache_resp_tag_array.sv - direct-mapped valid+tag store
//
// Purpose: 1024 x (valid + 13-bit tag) with a combinational lookup port and
// a synchronous install port; all valid bits clear on reset.
// Ports: clk, rstn; lookup_index_i, lookup_tag_i -> hit_o;
// install_en_i, install_index_i, install_tag_i.
module cache_resp_tag_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] lookup_index_i,
  input  logic [TAG_W-1:0]   lookup_tag_i,
  output logic               hit_o,
  input  logic               install_en_i,
  input  logic [INDEX_W-1:0] install_index_i,
  input  logic [TAG_W-1:0]   install_tag_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];

  assign hit_o = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);

  // Valid bits carry the reset; tag contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (install_en_i) begin
      valid_q[install_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (install_en_i) begin
      tag_q[install_index_i] <= install_tag_i;
    end
  end

endmodule

// File: rtl/cache_resp_model.sv
// rtl/cache_resp_model.sv - cycle-accurate cache responder with hit/miss latency
//
// Purpose: answers pulsed core read/write requests with one-cycle fin
// completions after HIT_LAT or MISS_LAT cycles, over a 2^MEM_AW-word RAM.
// Ports: clk, rstn (sync, active-low); bus (cache_resp_model_if.slave);
// with CACHE_RESP_STATS_EN defined: stat_hit_cnt, stat_miss_cnt, stat_drop_cnt.
module cache_resp_model
  import cache_pkg::*;
#(
  parameter int HIT_LAT  = 2,
  parameter int MISS_LAT = 8,
  parameter int MEM_AW   = 10
) (
  input  logic               clk,
  input  logic               rstn,
  cache_resp_model_if.slave  bus
`ifdef CACHE_RESP_STATS_EN
  ,
  output logic [31:0]        stat_hit_cnt,
  output logic [31:0]        stat_miss_cnt,
  output logic [15:0]        stat_drop_cnt
`endif
);

  // LOOKUP already accounts for two of the latency cycles (en cycle + LOOKUP).
  localparam logic [7:0] HIT_LOAD  = 8'(HIT_LAT - 2);
  localparam logic [7:0] MISS_LOAD = 8'(MISS_LAT - 2);

  cache_state_e      state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              miss_q, miss_d;
  logic              rd_fin_q, rd_fin_d;
  logic              wr_fin_q, wr_fin_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              tag_hit;
  logic              go_resp;
  logic              resp_done;

  logic [DATA_W-1:0] ram_q [2**MEM_AW];

  cache_resp_tag_array u_tags (
    .clk             (clk),
    .rstn            (rstn),
    .lookup_index_i  (addr_index(addr_q)),
    .lookup_tag_i    (addr_tag(addr_q)),
    .hit_o           (tag_hit),
    .install_en_i    (resp_done && miss_q),
    .install_index_i (addr_index(addr_q)),
    .install_tag_i   (addr_tag(addr_q))
  );

  assign resp_done = (state_q == ST_RESP);

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    miss_d      = miss_q;
    rd_fin_d    = 1'b0;
    wr_fin_d    = 1'b0;
    rd_data_d   = rd_data_q;
    go_resp     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Write wins a collision; the read waits in the pending slot.
        if (bus.core2cache_wr_en) begin
          op_wr_d     = 1'b1;
          addr_d      = bus.core2cache_wr_addr;
          data_d      = bus.core2cache_wr_data;
          pend_d      = bus.core2cache_rd_en;
          pend_addr_d = bus.core2cache_rd_addr;
          state_d     = ST_LOOKUP;
        end else if (bus.core2cache_rd_en) begin
          op_wr_d = 1'b0;
          addr_d  = bus.core2cache_rd_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        miss_d = !tag_hit;
        cnt_d  = tag_hit ? HIT_LOAD : MISS_LOAD;
        if (cnt_d == 8'd0) begin
          go_resp = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          go_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          op_wr_d = 1'b0;
          addr_d  = pend_addr_q;
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so fin/rd_data load on the edge into RESP.
    if (go_resp) begin
      state_d  = ST_RESP;
      cnt_d    = 8'd0;
      wr_fin_d = op_wr_q;
      rd_fin_d = !op_wr_q;
      if (!op_wr_q) begin
        rd_data_d = ram_q[addr_q[MEM_AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      cnt_q       <= 8'd0;
      miss_q      <= 1'b0;
      rd_fin_q    <= 1'b0;
      wr_fin_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
      miss_q      <= miss_d;
      rd_fin_q    <= rd_fin_d;
      wr_fin_q    <= wr_fin_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // RAM is committed at the end of RESP so a pending read that follows sees it.
  always_ff @(posedge clk) begin
    if (rstn && resp_done && op_wr_q) begin
      ram_q[addr_q[MEM_AW-1:0]] <= data_q;
    end
  end

  assign bus.cache2core_rd_fin  = rd_fin_q;
  assign bus.cache2core_wr_fin  = wr_fin_q;
  assign bus.cache2core_rd_data = rd_data_q;

`ifdef CACHE_RESP_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;
  logic [1:0]  drop_inc;

  // Both enables ignored in one cycle count as two drops.
  assign drop_inc = (state_q != ST_IDLE)
                  ? ({1'b0, bus.core2cache_rd_en} + {1'b0, bus.core2cache_wr_en})
                  : 2'd0;
  assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_inc};

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (state_q == ST_LOOKUP) begin
      if (tag_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_hit_cnt  = hit_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cache_resp_model.sv
// tb/tb_cache_resp_model.sv - self-checking bench for cache_resp_model
module tb_cache_resp_model;

  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = 8;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  cache_resp_model_if bus_if ();

`ifdef CACHE_RESP_STATS_EN
  logic [31:0] stat_hit_cnt;
  logic [31:0] stat_miss_cnt;
  logic [15:0] stat_drop_cnt;
`endif

  cache_resp_model #(
    .HIT_LAT  (HIT_LAT),
    .MISS_LAT (MISS_LAT),
    .MEM_AW   (10)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
`ifdef CACHE_RESP_STATS_EN
    ,
    .stat_hit_cnt  (stat_hit_cnt),
    .stat_miss_cnt (stat_miss_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which tag each line holds, RAM words by addr[9:0],
  // the value rd_data should be holding, and event counts.
  logic [12:0] m_tag [int];
  logic [31:0] m_mem [int];
  logic [31:0] m_hold;
  int          m_hits, m_misses, m_drops;
  logic [26:0] wlist [$];

  function automatic bit m_lookup(input logic [26:0] a);
    int idx;
    idx = int'(a[13:4]);
    return m_tag.exists(idx) && (m_tag[idx] == a[26:14]);
  endfunction

  // Returns the latency of an access and updates tag state and counters.
  function automatic int m_access(input logic [26:0] a);
    int idx;
    idx = int'(a[13:4]);
    if (m_lookup(a)) begin
      m_hits++;
      return HIT_LAT;
    end
    m_misses++;
    m_tag[idx] = a[26:14];
    return MISS_LAT;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_stats(input string name);
`ifdef CACHE_RESP_STATS_EN
    check({name, "_hits"},   stat_hit_cnt,          32'(m_hits));
    check({name, "_misses"}, stat_miss_cnt,         32'(m_misses));
    check({name, "_drops"},  {16'd0, stat_drop_cnt}, 32'(m_drops));
`endif
  endtask

  // One transaction: optional write, optional read (both = collision case).
  // inj_k > 0 pulses a stray wr_en k cycles in; rst_k > 0 pulses reset.
  task automatic run_op(input string name, input bit wr, input bit rd,
                        input logic [26:0] waddr, input logic [31:0] wdata,
                        input logic [26:0] raddr, input int inj_k, input int rst_k);
    int exp_w, exp_r, got_w, got_r, n_w, n_r, n_both, last;
    logic [31:0] exp_data, got_data;
    exp_w = -1;
    exp_r = -1;
    exp_data = '0;
    got_data = '0;
    if (wr) begin
      exp_w = m_access(waddr);
      m_mem[int'(waddr[9:0])] = wdata;
      wlist.push_back(waddr);
    end
    if (rd) begin
      exp_r = (wr ? exp_w : 0) + m_access(raddr);
      exp_data = m_mem[int'(raddr[9:0])];
    end
    if (inj_k > 0) m_drops++;
    last = ((exp_w > exp_r) ? exp_w : exp_r) + 3;
    if (rst_k > 0) begin
      exp_w = -1;
      exp_r = -1;
      last = MISS_LAT + 6;
    end

    @(negedge clk);
    bus_if.core2cache_wr_en   = wr;
    bus_if.core2cache_rd_en   = rd;
    bus_if.core2cache_wr_addr = waddr;
    bus_if.core2cache_wr_data = wdata;
    bus_if.core2cache_rd_addr = raddr;

    got_w = -1; got_r = -1; n_w = 0; n_r = 0; n_both = 0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (bus_if.cache2core_wr_fin) begin
        n_w++;
        if (got_w < 0) got_w = k;
      end
      if (bus_if.cache2core_rd_fin) begin
        n_r++;
        if (got_r < 0) begin
          got_r = k;
          got_data = bus_if.cache2core_rd_data;
        end
      end
      if (bus_if.cache2core_wr_fin && bus_if.cache2core_rd_fin) n_both++;
      bus_if.core2cache_rd_en = 1'b0;
      bus_if.core2cache_wr_en = (k == inj_k);
      bus_if.core2cache_wr_addr = 27'($urandom);
      bus_if.core2cache_wr_data = $urandom;
      rstn = (k != rst_k);
    end
    rstn = 1'b1;

    if (rst_k > 0) begin
      m_tag.delete();
      m_hits = 0;
      m_misses = 0;
      m_drops = 0;
      m_hold = '0;
    end

    check({name, "_wr_fin_cycle"}, 32'(got_w), 32'(exp_w));
    check({name, "_rd_fin_cycle"}, 32'(got_r), 32'(exp_r));
    check({name, "_wr_fin_count"}, 32'(n_w),   32'(exp_w >= 0 ? 1 : 0));
    check({name, "_rd_fin_count"}, 32'(n_r),   32'(exp_r >= 0 ? 1 : 0));
    check({name, "_fin_overlap"},  32'(n_both), 32'd0);
    if (rd && rst_k == 0) begin
      check({name, "_rd_data"}, got_data, exp_data);
      m_hold = exp_data;
    end
    check({name, "_rd_data_hold"}, bus_if.cache2core_rd_data, m_hold);
    check_stats(name);
  endtask

  initial begin
    logic [26:0] a, b;
    logic [31:0] d;
    int sel;
    checks = 0;
    failures = 0;
    m_hits = 0;
    m_misses = 0;
    m_drops = 0;
    m_hold = '0;
    rstn = 1'b0;
    bus_if.core2cache_rd_en   = 1'b0;
    bus_if.core2cache_wr_en   = 1'b0;
    bus_if.core2cache_rd_addr = '0;
    bus_if.core2cache_wr_addr = '0;
    bus_if.core2cache_wr_data = '0;

    repeat (3) @(negedge clk);
    check("reset_rd_fin",  {31'd0, bus_if.cache2core_rd_fin}, 32'd0);
    check("reset_wr_fin",  {31'd0, bus_if.cache2core_wr_fin}, 32'd0);
    check("reset_rd_data", bus_if.cache2core_rd_data,         32'd0);
    check_stats("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_op("cold_wr",    1'b1, 1'b0, 27'h000001C, 32'h0000_0001, '0, 0, 0);
    run_op("hit_rd",     1'b0, 1'b1, '0, '0, 27'h000001C, 0, 0);
    run_op("alias_wr",   1'b1, 1'b0, 27'h200001C, 32'hA5A5_0F0F, '0, 0, 0);
    run_op("alias_rd",   1'b0, 1'b1, '0, '0, 27'h000001C, 0, 0);
    run_op("collide",    1'b1, 1'b1, 27'h0000040, 32'h0000_0005, 27'h0000040, 0, 0);
    run_op("drop_wait",  1'b1, 1'b0, 27'h0000080, 32'h1234_5678, '0, 3, 0);
    run_op("rst_wait",   1'b0, 1'b1, '0, '0, 27'h200001C, 0, 4);
    run_op("post_rst",   1'b0, 1'b1, '0, '0, 27'h200001C, 0, 0);
    run_op("post_rst_h", 1'b0, 1'b1, '0, '0, 27'h200001C, 0, 0);

    for (int i = 0; i < 30; i++) begin
      a = {13'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      d = $urandom;
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        run_op("rnd_wr", 1'b1, 1'b0, a, d, '0, 0, 0);
      end else begin
        if (sel == 2) wlist.push_back(a);
        b = wlist[$urandom_range(0, wlist.size() - 1)];
        if ($urandom_range(0, 1) == 1) b[26:14] = 13'($urandom_range(0, 3));
        if (sel == 2) void'(wlist.pop_back());
        run_op(sel == 2 ? "rnd_both" : "rnd_rd", sel == 2, 1'b1, a, d, b, 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
